// File: rtl/pc_redirect_unit_if.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit_if
// Purpose : bundles the branch-resolution inputs and the fetch-PC / flush
//           outputs of pc_redirect_unit into a single interface.
// Signals :
//   stall, TakeBranch, UncondBr, cond_addr19, br_addr26, branch_pc,
//   br_reg_en, br_reg_target              driven by the pipeline (master)
//   pc, pc_plus4, flush, redirect,
//   branch_taken_count                    driven by pc_redirect_unit (slave)
// ---------------------------------------------------------------------------
interface pc_redirect_unit_if #(
    parameter int ADDR_WIDTH = 64
);
    logic                  stall;
    logic                  TakeBranch;
    logic                  UncondBr;
    logic [18:0]           cond_addr19;
    logic [25:0]           br_addr26;
    logic [ADDR_WIDTH-1:0] branch_pc;
    logic                  br_reg_en;
    logic [ADDR_WIDTH-1:0] br_reg_target;
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] pc_plus4;
    logic                  flush;
    logic                  redirect;
    logic [31:0]           branch_taken_count;

    modport master (
        output stall, TakeBranch, UncondBr, cond_addr19, br_addr26,
               branch_pc, br_reg_en, br_reg_target,
        input  pc, pc_plus4, flush, redirect, branch_taken_count
    );

    modport slave (
        input  stall, TakeBranch, UncondBr, cond_addr19, br_addr26,
               branch_pc, br_reg_en, br_reg_target,
        output pc, pc_plus4, flush, redirect, branch_taken_count
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// ---------------------------------------------------------------------------
// pc_redirect_unit
// Purpose : fetch program counter plus branch-redirect stage. Computes the
//           PC-relative branch target (or takes a BR register target),
//           updates the PC and holds flush high for FLUSH_CYCLES unstalled
//           cycles after each accepted redirect.
// Ports   :
//   clk  - pipeline clock, rising edge
//   rst  - synchronous reset, active-low
//   bus  - pc_redirect_unit_if.slave (branch inputs, pc/flush outputs)
// Optional: define PC_REDIRECT_STATS_EN to enable the saturating
//           accepted-redirect counter; otherwise branch_taken_count is 0.
// ---------------------------------------------------------------------------
module pc_redirect_unit #(
    parameter int                    ADDR_WIDTH   = 64,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = '0,
    parameter int                    FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    pc_redirect_unit_if.slave   bus
);

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [3:0]            r_cnt;
    logic                  r_flush;
    logic                  r_redirect;

    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic [3:0]            w_cnt_nxt;
    logic                  w_flush_nxt;
    logic                  w_accept;
    logic [ADDR_WIDTH-1:0] w_pc_plus4;
    logic [ADDR_WIDTH-1:0] w_sext;
    logic [ADDR_WIDTH-1:0] w_target;

    assign w_pc_plus4 = r_pc + {{(ADDR_WIDTH-3){1'b0}}, 3'd4};

    // Sign-extend the selected word offset, scale to bytes, add to branch PC.
    assign w_sext   = bus.UncondBr ? {{(ADDR_WIDTH-26){bus.br_addr26[25]}}, bus.br_addr26}
                                   : {{(ADDR_WIDTH-19){bus.cond_addr19[18]}}, bus.cond_addr19};
    assign w_target = bus.branch_pc + (w_sext << 2);

    // Next-state, next-PC and flush-counter decisions.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        w_flush_nxt = r_flush;
        w_accept    = 1'b0;
        case (r_state)
            RUN: begin
                w_flush_nxt = 1'b0;
                // Redirects win over stall: the resolved branch must not be lost.
                if (bus.br_reg_en) begin
                    w_pc_nxt = bus.br_reg_target;
                    w_accept = 1'b1;
                end else if (bus.TakeBranch) begin
                    w_pc_nxt = w_target;
                    w_accept = 1'b1;
                end else if (!bus.stall) begin
                    w_pc_nxt = w_pc_plus4;
                end else begin
                    w_pc_nxt = r_pc;
                end
                if (w_accept) begin
                    w_state_nxt = FLUSH;
                    w_cnt_nxt   = 4'(FLUSH_CYCLES);
                    w_flush_nxt = 1'b1;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            FLUSH: begin
                // Branch inputs here come from wrong-path instructions: ignored.
                w_flush_nxt = 1'b1;
                if (!bus.stall) begin
                    w_pc_nxt  = w_pc_plus4;
                    w_cnt_nxt = r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        w_state_nxt = RUN;
                        w_flush_nxt = 1'b0;
                    end else begin
                        w_state_nxt = FLUSH;
                    end
                end else begin
                    w_pc_nxt  = r_pc;
                    w_cnt_nxt = r_cnt;
                end
            end
            default: begin
                w_state_nxt = RUN;
                w_cnt_nxt   = 4'd0;
                w_flush_nxt = 1'b0;
            end
        endcase
    end

    // State, PC, flush counter and registered flags.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_cnt      <= 4'd0;
            r_flush    <= 1'b0;
            r_redirect <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_cnt      <= w_cnt_nxt;
            r_flush    <= w_flush_nxt;
            r_redirect <= w_accept;
        end
    end

`ifdef PC_REDIRECT_STATS_EN
    logic [31:0] r_taken_count;

    // Saturating count of accepted redirects.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_taken_count <= 32'd0;
        end else if (w_accept && (r_taken_count != 32'hFFFF_FFFF)) begin
            r_taken_count <= r_taken_count + 32'd1;
        end else begin
            r_taken_count <= r_taken_count;
        end
    end

    assign bus.branch_taken_count = r_taken_count;
`else
    assign bus.branch_taken_count = 32'd0;
`endif

    assign bus.pc       = r_pc;
    assign bus.pc_plus4 = w_pc_plus4;
    assign bus.flush    = r_flush;
    assign bus.redirect = r_redirect;

endmodule
